uart_calc_engine: RTL

- Byte-stream command engine that sits between the UART Receiver/Transmitter pair and replaces hard-wired 3-digit operand decoding.
- Parses two ASCII decimal operand lines of parametrised width and digit count, then adds or subtracts them.
- Formats a decimal result line and drives it byte-by-byte into the Transmitter through its start/done handshake.
- Also exposes the binary result and an error flag for on-chip consumers.

---
 rtl/uart_calc_engine.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/uart_calc_engine.sv
// uart_calc_engine: parses two ASCII decimal operand lines (A, then B with an
// optional leading '-'), adds or subtracts them, converts the result to BCD and
// streams "SUM:/DIF:<digits> COUT:<c>\n" (or "ERR\n") to the UART transmitter.
// Ports: clk/reset; rx_data/rx_valid in; tx_data/tx_start out, tx_done in;
// busy, result/result_cout/result_valid, err, rx_drop out.
module uart_calc_engine #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned DIGITS = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       rx_data,
  input  logic             rx_valid,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_done,
  output logic             busy,
  output logic [WIDTH-1:0] result,
  output logic             result_cout,
  output logic             result_valid,
  output logic             err,
  output logic             rx_drop
);

  localparam int unsigned MSG_LEN = DIGITS + 12;
  localparam int unsigned IW      = $clog2(MSG_LEN);
  localparam int unsigned DW      = $clog2(DIGITS + 1);
  localparam int unsigned CW      = $clog2(WIDTH + 1);
  localparam int unsigned AW      = WIDTH + 4;
  localparam int unsigned BW      = 4 * DIGITS;

  typedef enum logic [2:0] {PARSE_A, PARSE_B, CALC, CONV, SEND, SEND_ERR} state_t;

  state_t          state_q, state_d;
  logic [WIDTH-1:0] acc, a_val, bin;
  logic [DW-1:0]    dcnt;
  logic             sub;
  logic [BW-1:0]    bcd, bcd_adj;
  logic [CW-1:0]    conv_cnt;
  logic [IW-1:0]    idx;
  logic [AW-1:0]    acc_next;
  logic [WIDTH:0]   sum_w, dif_w;
  logic             parsing, is_digit, is_term, is_minus;
  logic             digit_ok, minus_ok, do_latch, parse_err, last_byte;

  function automatic logic [7:0] msg_byte(input int unsigned i, input logic s,
                                          input logic c, input logic [BW-1:0] b);
    logic [7:0]  r;
    int unsigned k;
    r = 8'h0a;
    if (i < 4) begin
      case (i)
        0:       r = s ? "D" : "S";
        1:       r = s ? "I" : "U";
        2:       r = s ? "F" : "M";
        default: r = ":";
      endcase
    end else if (i < 4 + DIGITS) begin
      k = DIGITS - 1 - (i - 4);
      r = {4'h3, b[4*k +: 4]};
    end else begin
      case (i - (4 + DIGITS))
        0:       r = " ";
        1:       r = "C";
        2:       r = "O";
        3:       r = "U";
        4:       r = "T";
        5:       r = ":";
        6:       r = {7'h18, c};
        default: r = 8'h0a;
      endcase
    end
    return r;
  endfunction

  function automatic logic [7:0] err_byte(input int unsigned i);
    case (i)
      0:       return "E";
      1, 2:    return "R";
      default: return 8'h0a;
    endcase
  endfunction

  always_comb begin
    parsing   = (state_q == PARSE_A) || (state_q == PARSE_B);
    busy      = !parsing;
    is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    is_term   = (rx_data == 8'd10) || (rx_data == 8'd13);
    is_minus  = (rx_data == 8'h2d);
    acc_next  = {4'b0, acc} * AW'(10) + AW'(rx_data[3:0]);
    digit_ok  = is_digit && (dcnt != DW'(DIGITS)) && (acc_next[AW-1:WIDTH] == '0);
    minus_ok  = (state_q == PARSE_B) && is_minus && (dcnt == '0) && !sub;
    do_latch  = rx_valid && parsing && is_term && (dcnt != '0);
    // an empty line is ignored unless it follows a lone '-'
    parse_err = rx_valid && parsing &&
                !(digit_ok || minus_ok || (is_term && !((dcnt == '0) && sub)));
    last_byte = (state_q == SEND) ? (idx == IW'(MSG_LEN - 1)) : (idx == IW'(3));
    sum_w     = {1'b0, a_val} + {1'b0, acc};
    dif_w     = {1'b0, a_val} - {1'b0, acc};
    bcd_adj   = bcd;
    for (int unsigned k = 0; k < DIGITS; k++) begin
      if (bcd[4*k +: 4] >= 4'd5) bcd_adj[4*k +: 4] = bcd[4*k +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PARSE_A:  if (parse_err) state_d = SEND_ERR; else if (do_latch) state_d = PARSE_B;
      PARSE_B:  if (parse_err) state_d = SEND_ERR; else if (do_latch) state_d = CALC;
      CALC:     state_d = CONV;
      CONV:     if (conv_cnt == CW'(WIDTH - 1)) state_d = SEND;
      SEND,
      SEND_ERR: if (tx_done && last_byte) state_d = PARSE_A;
      default:  state_d = PARSE_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= PARSE_A;
    else       state_q <= state_d;
  end

  // tx_start/tx_data are registered; the next byte is loaded on the tx_done edge
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0; a_val <= '0; bin <= '0; dcnt <= '0; sub <= 1'b0;
      bcd <= '0; conv_cnt <= '0; idx <= '0;
      tx_data <= '0; tx_start <= 1'b0; result <= '0; result_cout <= 1'b0;
      result_valid <= 1'b0; err <= 1'b0; rx_drop <= 1'b0;
    end else begin
      tx_start     <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      rx_drop      <= rx_valid && busy;
      case (state_q)
        PARSE_A, PARSE_B: begin
          if (parse_err) begin
            err      <= 1'b1;
            idx      <= '0;
            tx_start <= 1'b1;
            tx_data  <= err_byte(0);
          end else if (rx_valid) begin
            if (minus_ok) begin
              sub <= 1'b1;
            end else if (is_digit) begin
              acc  <= acc_next[WIDTH-1:0];
              dcnt <= dcnt + DW'(1);
            end else if (do_latch && (state_q == PARSE_A)) begin
              a_val <= acc;
              acc   <= '0;
              dcnt  <= '0;
            end
          end
        end
        CALC: begin
          result       <= sub ? dif_w[WIDTH-1:0] : sum_w[WIDTH-1:0];
          result_cout  <= sub ? dif_w[WIDTH] : sum_w[WIDTH];
          bin          <= sub ? dif_w[WIDTH-1:0] : sum_w[WIDTH-1:0];
          result_valid <= 1'b1;
          bcd          <= '0;
          conv_cnt     <= '0;
        end
        CONV: begin
          bcd      <= {bcd_adj[BW-2:0], bin[WIDTH-1]};
          bin      <= {bin[WIDTH-2:0], 1'b0};
          conv_cnt <= conv_cnt + CW'(1);
          if (conv_cnt == CW'(WIDTH - 1)) begin
            idx      <= '0;
            tx_start <= 1'b1;
            tx_data  <= msg_byte(0, sub, result_cout, bcd);
          end
        end
        SEND, SEND_ERR: begin
          if (tx_done) begin
            if (last_byte) begin
              acc <= '0; a_val <= '0; dcnt <= '0; sub <= 1'b0; idx <= '0;
            end else begin
              idx      <= idx + IW'(1);
              tx_start <= 1'b1;
              tx_data  <= (state_q == SEND) ? msg_byte(32'(idx) + 1, sub, result_cout, bcd)
                                            : err_byte(32'(idx) + 1);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
